mest_pro_mem_arbiter: RTL and testbench
=======================================

# mest_pro_mem_arbiter

Single-port arbiter and access sequencer for the MESTPro unified memory. Sits between three requesters — instruction fetch, execute-stage load/store, and the boot program loader — and the shared memory macro. Serializes their accesses, drives the memory's program-counter/data-address buses, select, chip-select and write-enable, and returns read data plus completion/error per requester. Fixed priority is loader > exec > fetch, with a starvation guard for fetch.

## Interface
- PC_BITS, 16, program address width (64K-word program space)
- ADDR_BITS, 8, data-space address width
- MEM_W, 16, memory word width (instruction width)
- MEM_LATENCY, 1, cycles from chip-select edge to valid `i_mem_dat`; legal range 1..4
- STARVE_LIMIT, 3, consecutive lost arbitrations after which fetch beats exec
- clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch read request; held until `o_if_gnt`
- i_if_addr  in  PC_BITS  fetch address
- o_if_gnt  out  1  one-cycle grant pulse
- o_if_done  out  1  one-cycle completion pulse; `o_rdata` valid
- i_ex_req  in  1  exec request; held until `o_ex_gnt`
- i_ex_we  in  1  1 = write, 0 = read
- i_ex_addr  in  ADDR_BITS  data address
- i_ex_wdata  in  MEM_W  write data
- o_ex_gnt  out  1  grant pulse
- o_ex_done  out  1  completion pulse
- i_ld_req  in  1  loader write request; held until `o_ld_gnt`
- i_ld_addr  in  PC_BITS  program address
- i_ld_wdata  in  MEM_W  instruction word
- o_ld_gnt  out  1  grant pulse
- o_ld_done  out  1  completion pulse
- o_rdata  out  MEM_W  read data for the current done pulse, shared by all requesters
- o_err  out  1  high with a done pulse when the memory flagged an error
- o_prog_counter  out  PC_BITS  memory program address
- o_mm_addr  out  ADDR_BITS  memory data address
- o_mm_dat  out  MEM_W  memory write data
- o_mm_select  out  1  0 = program space, 1 = data space
- o_cs  out  1  memory chip select
- o_we  out  1  memory write enable
- i_mem_dat  in  MEM_W  memory read data
- i_mem_error  in  1  memory error flag

## Operation
- FSM has four states: IDLE, ACCESS, WAIT, RESP.
- **Arbitration** happens at the clock edge ending IDLE or RESP.
  - Winner order: loader, then exec, then fetch.
  - Exception: if `starve_cnt == STARVE_LIMIT` and `i_if_req` is high, fetch beats exec. The loader still wins.
  - No request: go to IDLE.
- **Capture:** on the arbitration edge, the winner's address, data, we and an owner tag are registered.
- **ACCESS** lasts one cycle.
  - `o_cs` = 1, and the winner's `o_*_gnt` = 1.
  - `o_we`: fetch 0, exec `i_ex_we`, loader 1.
  - `o_mm_select`: exec 1, otherwise 0.
  - Address goes on `o_prog_counter` (fetch/loader) or `o_mm_addr` (exec). The unused address bus holds its previous value.
  - Next state: WAIT.
- **WAIT** lasts MEM_LATENCY cycles, counted by a down-counter, with `o_cs` = 0 and `o_we` = 0.
  - On the last WAIT cycle, `i_mem_dat` and `i_mem_error` are registered.
  - Writes register them too; `o_rdata` is don't-care for writes.
- **RESP** lasts one cycle.
  - The owner's `o_*_done` = 1, `o_rdata` = captured data, `o_err` = captured error.
  - Arbitration is performed at the end of RESP, so back-to-back service needs no IDLE cycle.
- **Starvation counter** `starve_cnt` (saturating at STARVE_LIMIT):
  - +1 at each arbitration edge where `i_if_req` = 1 and exec wins.
  - Cleared when fetch wins.
  - Unchanged when the loader wins or fetch is idle.
- Requests and their payloads are ignored outside arbitration edges. A requester may drop req in its grant cycle or later.
- At most one access is in flight. Requests that arrive while ACCESS, WAIT or RESP is in progress wait.

## Timing
- Reset values: state IDLE, `starve_cnt` 0, and every output 0, including the address/data buses, `o_rdata` and all gnt/done/err.
- Single access, request first sampled in IDLE at the end of cycle 0:
  - cycle 1: ACCESS and gnt
  - cycles 2..1+MEM_LATENCY: WAIT
  - cycle 2+MEM_LATENCY: RESP and done
- Service period is MEM_LATENCY+2 cycles per access. Latency from req to done is 2+MEM_LATENCY cycles (3 at the default).
- gnt and done are exactly one cycle wide and never both asserted to the same requester.
- Reset asserted in any state: next cycle is IDLE with all outputs 0. An in-flight access is abandoned and no done or err is issued for it.
- `i_mem_error` is only observed in the capture cycle. Error pulses outside it are ignored.

## Test plan
- **Fetch read, MEM_LATENCY = 1:** `i_if_req` with `i_if_addr = 16'h0010`, mem returns `16'hA5C3`. Expect gnt in cycle 1 with `o_cs` = 1, `o_we` = 0, `o_mm_select` = 0 and `o_prog_counter` = `16'h0010`; then `o_if_done` in cycle 3 with `o_rdata` = `16'hA5C3` and `o_err` = 0.
- **Exec write:** `i_ex_we` = 1, `i_ex_addr = 8'h3F`, `i_ex_wdata = 16'h00FF`. Expect an ACCESS cycle with `o_mm_select` = 1, `o_we` = 1, `o_mm_addr` = `8'h3F` and `o_mm_dat` = `16'h00FF`; `o_ex_done` 2 cycles later.
- **Simultaneous requests:** loader, exec and fetch all requesting in the same cycle. Grants in order ld, ex, if at cycles 1, 4 and 7. No idle cycle between accesses.
- **Starvation guard, STARVE_LIMIT = 3:** exec and fetch both requesting continuously. Exec wins 3 arbitrations, fetch wins the 4th, then exec resumes.
- **Error path:** exec read with `i_mem_error` = 1 in the capture cycle. `o_ex_done` and `o_err` both 1 in RESP; `o_err` is 0 on the following fetch completion.
- **Reset mid-WAIT, MEM_LATENCY = 3:** assert `i_reset` in the 2nd WAIT cycle. All outputs 0 next cycle and no done ever issued; a fetch request after reset release completes normally in 5 cycles.

Source files
------------

// File: rtl/mest_pro_mem_arbiter.sv
// MESTPro unified-memory arbiter: serializes loader/exec/fetch accesses onto the
// single-port memory macro with fixed priority and a fetch starvation guard.
module mest_pro_mem_arbiter #(
  parameter int PC_BITS      = 16,
  parameter int ADDR_BITS    = 8,
  parameter int MEM_W        = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_if_req,
  input  logic [PC_BITS-1:0]   i_if_addr,
  output logic                 o_if_gnt,
  output logic                 o_if_done,
  input  logic                 i_ex_req,
  input  logic                 i_ex_we,
  input  logic [ADDR_BITS-1:0] i_ex_addr,
  input  logic [MEM_W-1:0]     i_ex_wdata,
  output logic                 o_ex_gnt,
  output logic                 o_ex_done,
  input  logic                 i_ld_req,
  input  logic [PC_BITS-1:0]   i_ld_addr,
  input  logic [MEM_W-1:0]     i_ld_wdata,
  output logic                 o_ld_gnt,
  output logic                 o_ld_done,
  output logic [MEM_W-1:0]     o_rdata,
  output logic                 o_err,
  output logic [PC_BITS-1:0]   o_prog_counter,
  output logic [ADDR_BITS-1:0] o_mm_addr,
  output logic [MEM_W-1:0]     o_mm_dat,
  output logic                 o_mm_select,
  output logic                 o_cs,
  output logic                 o_we,
  input  logic [MEM_W-1:0]     i_mem_dat,
  input  logic                 i_mem_error
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_EX, OWN_LD} owner_t;

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [1:0]      WAIT_LOAD  = 2'(MEM_LATENCY - 1);

  state_t                 r_state, w_next;
  owner_t                 r_owner, w_win;
  logic                   w_arb;
  logic [SW-1:0]          r_starve;
  logic [1:0]             r_wait_cnt;
  logic                   r_we, r_sel, r_err;
  logic [PC_BITS-1:0]     r_pc;
  logic [ADDR_BITS-1:0]   r_mm_addr;
  logic [MEM_W-1:0]       r_dat, r_rdata;

  assign w_arb = (r_state == S_IDLE) || (r_state == S_RESP);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_win = OWN_NONE;
    if (i_ld_req)                               w_win = OWN_LD;
    else if (i_if_req && r_starve == STARVE_MAX) w_win = OWN_IF;
    else if (i_ex_req)                          w_win = OWN_EX;
    else if (i_if_req)                          w_win = OWN_IF;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: w_next = (w_win != OWN_NONE) ? S_ACCESS : S_IDLE;
      S_ACCESS:       w_next = S_WAIT;
      S_WAIT:         if (r_wait_cnt == 2'd0) w_next = S_RESP;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_NONE;
      r_starve   <= '0;
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
      r_sel      <= 1'b0;
      r_err      <= 1'b0;
      r_pc       <= '0;
      r_mm_addr  <= '0;
      r_dat      <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_arb && w_win != OWN_NONE) begin
        r_owner <= w_win;
        case (w_win)
          OWN_LD: begin
            r_pc  <= i_ld_addr;
            r_dat <= i_ld_wdata;
            r_we  <= 1'b1;
            r_sel <= 1'b0;
          end
          OWN_EX: begin
            r_mm_addr <= i_ex_addr;
            r_dat     <= i_ex_wdata;
            r_we      <= i_ex_we;
            r_sel     <= 1'b1;
          end
          default: begin
            r_pc  <= i_if_addr;
            r_we  <= 1'b0;
            r_sel <= 1'b0;
          end
        endcase
      end
      // Starvation only accrues when fetch was actually waiting and lost to exec.
      if (w_arb) begin
        if (w_win == OWN_IF)
          r_starve <= '0;
        else if (w_win == OWN_EX && i_if_req && r_starve != STARVE_MAX)
          r_starve <= r_starve + 1'b1;
      end
      if (r_state == S_ACCESS)
        r_wait_cnt <= WAIT_LOAD;
      else if (r_state == S_WAIT && r_wait_cnt != 2'd0)
        r_wait_cnt <= r_wait_cnt - 1'b1;
      if (r_state == S_WAIT && r_wait_cnt == 2'd0) begin
        r_rdata <= i_mem_dat;
        r_err   <= i_mem_error;
      end
    end
  end

  assign o_cs           = (r_state == S_ACCESS);
  assign o_we           = (r_state == S_ACCESS) && r_we;
  assign o_if_gnt       = (r_state == S_ACCESS) && (r_owner == OWN_IF);
  assign o_ex_gnt       = (r_state == S_ACCESS) && (r_owner == OWN_EX);
  assign o_ld_gnt       = (r_state == S_ACCESS) && (r_owner == OWN_LD);
  assign o_if_done      = (r_state == S_RESP) && (r_owner == OWN_IF);
  assign o_ex_done      = (r_state == S_RESP) && (r_owner == OWN_EX);
  assign o_ld_done      = (r_state == S_RESP) && (r_owner == OWN_LD);
  assign o_err          = (r_state == S_RESP) && r_err;
  assign o_rdata        = r_rdata;
  assign o_prog_counter = r_pc;
  assign o_mm_addr      = r_mm_addr;
  assign o_mm_dat       = r_dat;
  assign o_mm_select    = r_sel;

endmodule

// File: tb/tb_mest_pro_mem_arbiter.sv
// Directed bench for mest_pro_mem_arbiter: one instance at MEM_LATENCY=1 and one at
// MEM_LATENCY=3 share all stimulus; cycle numbers below count from the request cycle.
module tb_mest_pro_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_if_req = 1'b0, i_ex_req = 1'b0, i_ex_we = 1'b0, i_ld_req = 1'b0;
  logic [15:0] i_if_addr = '0, i_ld_addr = '0, i_ex_wdata = '0, i_ld_wdata = '0;
  logic [7:0]  i_ex_addr = '0;
  logic [15:0] i_mem_dat = '0;
  logic        i_mem_error = 1'b0;

  logic        o_if_gnt, o_if_done, o_ex_gnt, o_ex_done, o_ld_gnt, o_ld_done;
  logic        o_err, o_mm_select, o_cs, o_we;
  logic [15:0] o_rdata, o_prog_counter, o_mm_dat;
  logic [7:0]  o_mm_addr;

  logic        d3_if_gnt, d3_if_done, d3_ex_gnt, d3_ex_done, d3_ld_gnt, d3_ld_done;
  logic        d3_err, d3_mm_select, d3_cs, d3_we;
  logic [15:0] d3_rdata, d3_prog_counter, d3_mm_dat;
  logic [7:0]  d3_mm_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mest_pro_mem_arbiter #(.MEM_LATENCY(1)) dut (
    .clk(clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt), .o_if_done(o_if_done),
    .i_ex_req(i_ex_req), .i_ex_we(i_ex_we), .i_ex_addr(i_ex_addr), .i_ex_wdata(i_ex_wdata),
    .o_ex_gnt(o_ex_gnt), .o_ex_done(o_ex_done),
    .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_wdata(i_ld_wdata),
    .o_ld_gnt(o_ld_gnt), .o_ld_done(o_ld_done),
    .o_rdata(o_rdata), .o_err(o_err), .o_prog_counter(o_prog_counter),
    .o_mm_addr(o_mm_addr), .o_mm_dat(o_mm_dat), .o_mm_select(o_mm_select),
    .o_cs(o_cs), .o_we(o_we), .i_mem_dat(i_mem_dat), .i_mem_error(i_mem_error)
  );

  mest_pro_mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(d3_if_gnt), .o_if_done(d3_if_done),
    .i_ex_req(i_ex_req), .i_ex_we(i_ex_we), .i_ex_addr(i_ex_addr), .i_ex_wdata(i_ex_wdata),
    .o_ex_gnt(d3_ex_gnt), .o_ex_done(d3_ex_done),
    .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_wdata(i_ld_wdata),
    .o_ld_gnt(d3_ld_gnt), .o_ld_done(d3_ld_done),
    .o_rdata(d3_rdata), .o_err(d3_err), .o_prog_counter(d3_prog_counter),
    .o_mm_addr(d3_mm_addr), .o_mm_dat(d3_mm_dat), .o_mm_select(d3_mm_select),
    .o_cs(d3_cs), .o_we(d3_we), .i_mem_dat(i_mem_dat), .i_mem_error(i_mem_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_if_win [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int         k;
    logic       seen_done;

    // Reset state
    tick();
    tick();
    check("rst_handshake", {o_if_gnt, o_ex_gnt, o_ld_gnt, o_if_done, o_ex_done, o_ld_done}, 0);
    check("rst_mem_ctl", {o_cs, o_we, o_mm_select, o_err}, 0);
    check("rst_buses", {o_prog_counter, o_mm_addr, o_mm_dat}, 0);
    check("rst_rdata", o_rdata, 0);

    // Fetch read
    i_reset = 1'b0;
    i_if_req = 1'b1; i_if_addr = 16'h0010; i_mem_dat = 16'hA5C3;
    tick();                                   // cycle 1
    check("if_gnt", o_if_gnt, 1);
    check("if_access", {o_cs, o_we, o_mm_select}, 3'b100);
    check("if_pc", o_prog_counter, 16'h0010);
    i_if_req = 1'b0;
    tick();                                   // cycle 2
    check("if_wait", {o_cs, o_if_gnt, o_if_done}, 0);
    tick();                                   // cycle 3
    check("if_done", {o_if_done, o_if_gnt, o_err}, 3'b100);
    check("if_rdata", o_rdata, 16'hA5C3);
    tick();                                   // idle

    // Exec write
    i_ex_req = 1'b1; i_ex_we = 1'b1; i_ex_addr = 8'h3F; i_ex_wdata = 16'h00FF;
    tick();
    check("exw_gnt", o_ex_gnt, 1);
    check("exw_access", {o_cs, o_we, o_mm_select}, 3'b111);
    check("exw_addr", o_mm_addr, 8'h3F);
    check("exw_dat", o_mm_dat, 16'h00FF);
    check("exw_pc_hold", o_prog_counter, 16'h0010);
    i_ex_req = 1'b0;
    tick();
    tick();
    check("exw_done", {o_ex_done, o_ex_gnt}, 2'b10);
    tick();

    // Simultaneous requests
    i_ld_req = 1'b1; i_ld_addr = 16'h0200; i_ld_wdata = 16'h1234;
    i_ex_req = 1'b1; i_ex_we = 1'b0; i_ex_addr = 8'h05;
    i_if_req = 1'b1; i_if_addr = 16'h0020;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check($sformatf("sim_ld_gnt_c%0d", c), o_ld_gnt, c == 1);
      check($sformatf("sim_ex_gnt_c%0d", c), o_ex_gnt, c == 4);
      check($sformatf("sim_if_gnt_c%0d", c), o_if_gnt, c == 7);
      check($sformatf("sim_cs_c%0d", c), o_cs, (c == 1) || (c == 4) || (c == 7));
      check($sformatf("sim_done_c%0d", c), {o_ld_done, o_ex_done, o_if_done},
            {c == 3, c == 6, c == 9});
      if (c == 1) begin
        check("sim_ld_pc", o_prog_counter, 16'h0200);
        check("sim_ld_we", {o_we, o_mm_dat}, {1'b1, 16'h1234});
      end
      if (o_ld_gnt) i_ld_req = 1'b0;
      if (o_ex_gnt) i_ex_req = 1'b0;
      if (o_if_gnt) i_if_req = 1'b0;
    end
    tick();

    // Starvation guard: exec x3, fetch, exec
    i_ex_req = 1'b1; i_ex_we = 1'b0; i_if_req = 1'b1;
    for (int g = 0; g < 5; g++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (!(o_if_gnt || o_ex_gnt) && k < 10);
      check($sformatf("starve_period_%0d", g), k, (g == 0) ? 1 : 3);
      check($sformatf("starve_if_win_%0d", g), o_if_gnt, exp_if_win[g]);
      check($sformatf("starve_ex_win_%0d", g), o_ex_gnt, !exp_if_win[g]);
    end
    i_ex_req = 1'b0; i_if_req = 1'b0;
    tick();
    tick();
    tick();

    // Error path, then a clean fetch with an error pulse outside its capture cycle
    i_ex_req = 1'b1; i_ex_we = 1'b0; i_ex_addr = 8'h12; i_mem_dat = 16'hBEEF;
    tick();                                   // cycle 1
    check("err_ex_gnt", o_ex_gnt, 1);
    i_ex_req = 1'b0;
    tick();                                   // cycle 2: capture
    i_mem_error = 1'b1;
    tick();                                   // cycle 3: RESP
    i_mem_error = 1'b0;
    check("err_done_err", {o_ex_done, o_err}, 2'b11);
    check("err_rdata", o_rdata, 16'hBEEF);
    i_if_req = 1'b1; i_if_addr = 16'h0040; i_mem_dat = 16'h5555;
    tick();                                   // cycle 4: ACCESS
    check("err_if_gnt", o_if_gnt, 1);
    i_if_req = 1'b0;
    i_mem_error = 1'b1;
    tick();                                   // cycle 5: capture
    i_mem_error = 1'b0;
    tick();                                   // cycle 6: RESP
    check("err_if_done_clean", {o_if_done, o_err, o_ex_done}, 3'b100);
    check("err_if_rdata", o_rdata, 16'h5555);

    // Reset mid-WAIT on the MEM_LATENCY=3 instance
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_if_req = 1'b1; i_if_addr = 16'h0123; i_mem_dat = 16'h7777;
    tick();                                   // cycle 1
    check("rst3_gnt", {d3_if_gnt, d3_cs, d3_prog_counter}, {2'b11, 16'h0123});
    i_if_req = 1'b0;
    tick();                                   // cycle 2: WAIT 1
    tick();                                   // cycle 3: WAIT 2
    i_reset = 1'b1;
    tick();                                   // cycle 4
    i_reset = 1'b0;
    check("rst3_handshake", {d3_if_gnt, d3_ex_gnt, d3_ld_gnt, d3_if_done, d3_ex_done, d3_ld_done}, 0);
    check("rst3_ctl", {d3_cs, d3_we, d3_mm_select, d3_err}, 0);
    check("rst3_buses", {d3_prog_counter, d3_mm_addr, d3_mm_dat, d3_rdata}, 0);
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen_done |= d3_if_done | d3_ex_done | d3_ld_done | d3_err;
    end
    check("rst3_no_done", seen_done, 0);
    i_if_req = 1'b1; i_if_addr = 16'h0456;
    k = 0;
    do begin
      tick();
      k++;
      if (d3_if_gnt) i_if_req = 1'b0;
    end while (!d3_if_done && k < 10);
    check("rst3_latency", k, 5);
    check("rst3_rdata", {d3_if_done, d3_err, d3_rdata}, {2'b10, 16'h7777});
    check("rst3_pc", d3_prog_counter, 16'h0456);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
